memory_controller_32: RTL and testbench

Single-port memory/MMIO controller between the 32-bit CPU core's memory bus and a synchronous single-port SRAM plus a byte-wide transmit port. It accepts one read or write at a time and stalls the core through `cpu_ready` for a programmable number of wait states. It also decodes RAM, MMIO and illegal addresses, and records bus errors in a sticky status bit.

---
 rtl/memory_controller_32_if.sv | 25 ++
 rtl/memory_controller_32.sv | 174 +++++++++++++++++
 tb/tb_memory_controller_32.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_32_if.sv
// CPU memory bus between the core (master) and the memory controller (slave).
//   cpu_addr/cpu_wdata : byte address and store data, held while a request is pending
//   cpu_read/cpu_write : request strobes
//   cpu_rdata          : read data, valid while cpu_ready is high in DONE
//   cpu_rdata_oe       : high in DONE of a read, drives the top-level tristate bus
//   cpu_ready          : core advance enable
interface memory_controller_32_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_rdata_oe;
    logic        cpu_ready;

    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write,
        input  cpu_rdata, cpu_rdata_oe, cpu_ready
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
        output cpu_rdata, cpu_rdata_oe, cpu_ready
    );
endinterface

// File: rtl/memory_controller_32.sv
// Single-port memory/MMIO controller: one CPU read or write at a time to a
// synchronous SRAM (with programmable wait states), a byte-wide TX port or a
// status register. Illegal requests complete normally and set a sticky error.
//   clk, rst              : clock, asynchronous active-high reset
//   bus                   : CPU bus (slave side)
//   ram_addr/ram_wdata    : SRAM word address and write data
//   ram_en/ram_we         : SRAM enable / write enable (one-cycle pulse)
//   ram_rdata             : SRAM read data, valid the cycle after ram_en
//   io_tx_data/valid/ready: transmit byte handshake
//   bus_error             : sticky error flag, cleared by a STATUS write
module memory_controller_32 #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    memory_controller_32_if.slave   bus,
    output logic [ADDR_WIDTH-3:0]   ram_addr,
    output logic [31:0]             ram_wdata,
    output logic                    ram_en,
    output logic                    ram_we,
    input  logic [31:0]             ram_rdata,
    output logic [7:0]              io_tx_data,
    output logic                    io_tx_valid,
    input  logic                    io_tx_ready,
    output logic                    bus_error
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned WORD_W = ADDR_WIDTH - 2;
    localparam logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF;
    localparam logic [DATA_W-1:0] STATUS_ADDR = MMIO_BASE + 32'd4;

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_IO_TX, S_DONE} state_e;
    typedef enum logic [1:0] {C_RAM, C_TX, C_STATUS, C_ERR} cls_e;

    state_e              state_q, state_d;
    cls_e                req_cls_c;
    logic                req_c;
    logic [WORD_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                op_read_q;
    logic                op_write_q;
    logic [WCNT_W-1:0]   wait_cnt_q;
    logic                bus_error_q;
    logic                cpu_ready_c;
    logic                rdata_oe_c;

    assign req_c = bus.cpu_read | bus.cpu_write;

    // Request decode, first match wins
    always_comb begin
        req_cls_c = C_ERR;
        if (bus.cpu_read && bus.cpu_write) begin
            req_cls_c = C_ERR;
        end else if (bus.cpu_addr[1:0] != 2'b00) begin
            req_cls_c = C_ERR;
        end else if ((bus.cpu_addr >> ADDR_WIDTH) == 32'd0) begin
            req_cls_c = C_RAM;
        end else if (bus.cpu_addr == MMIO_BASE) begin
            req_cls_c = C_TX;
        end else if (bus.cpu_addr == STATUS_ADDR) begin
            req_cls_c = C_STATUS;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    case (req_cls_c)
                        C_RAM:   state_d = S_ACCESS;
                        C_TX:    state_d = bus.cpu_write ? S_IO_TX : S_DONE;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_ACCESS: state_d = S_WAIT;
            S_WAIT:   if (wait_cnt_q == '0) state_d = S_DONE;
            S_IO_TX:  if (io_tx_ready) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        io_tx_valid = 1'b0;
        rdata_oe_c  = 1'b0;
        cpu_ready_c = 1'b0;
        case (state_q)
            S_IDLE:   cpu_ready_c = !req_c;
            S_ACCESS: begin
                ram_en = 1'b1;
                ram_we = op_write_q;
            end
            S_IO_TX:  io_tx_valid = 1'b1;
            S_DONE: begin
                cpu_ready_c = 1'b1;
                rdata_oe_c  = op_read_q;
            end
            default: ;
        endcase
    end

    // Request latch, wait counter, read register and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            op_read_q   <= 1'b0;
            op_write_q  <= 1'b0;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_c) begin
                        addr_q     <= bus.cpu_addr[ADDR_WIDTH-1:2];
                        wdata_q    <= bus.cpu_wdata;
                        op_read_q  <= bus.cpu_read;
                        op_write_q <= bus.cpu_write;
                        case (req_cls_c)
                            C_TX:     rdata_q <= '0;
                            C_STATUS: begin
                                rdata_q <= {{(DATA_W-2){1'b0}}, bus_error_q, io_tx_ready};
                                if (bus.cpu_write) bus_error_q <= 1'b0;
                            end
                            C_ERR: begin
                                rdata_q     <= ERR_DATA;
                                bus_error_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ACCESS: wait_cnt_q <= WCNT_W'(WAIT_STATES);
                S_WAIT: begin
                    // ram_rdata is stable from the cycle after ram_en, so capture on the last wait cycle
                    if (wait_cnt_q == '0) begin
                        if (op_read_q) rdata_q <= ram_rdata;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr         = addr_q;
    assign ram_wdata        = wdata_q;
    assign io_tx_data       = wdata_q[7:0];
    assign bus_error        = bus_error_q;
    assign bus.cpu_rdata    = rdata_q;
    assign bus.cpu_rdata_oe = rdata_oe_c;
    assign bus.cpu_ready    = cpu_ready_c;
endmodule

// File: tb/tb_memory_controller_32.sv
module tb_memory_controller_32;
    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main DUT, WAIT_STATES = 2
    memory_controller_32_if bus();
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid, io_tx_ready, bus_error;

    memory_controller_32 dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .io_tx_data(io_tx_data), .io_tx_valid(io_tx_valid),
        .io_tx_ready(io_tx_ready), .bus_error(bus_error)
    );

    logic [31:0] mem [0:16383];
    initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    initial ram_rdata = 32'h0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    // Wait-state sweep DUTs with a pattern RAM stub: data = C0DE_0000 | word address
    memory_controller_32_if bus_a();
    memory_controller_32_if bus_b();
    logic [13:0] a_ram_addr, b_ram_addr;
    logic [31:0] a_ram_wdata, b_ram_wdata, a_ram_rdata, b_ram_rdata;
    logic        a_ram_en, a_ram_we, b_ram_en, b_ram_we;
    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_tx_valid, b_tx_valid, a_err, b_err;

    memory_controller_32 #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .bus(bus_a),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_en(a_ram_en), .ram_we(a_ram_we),
        .ram_rdata(a_ram_rdata), .io_tx_data(a_tx_data), .io_tx_valid(a_tx_valid),
        .io_tx_ready(1'b1), .bus_error(a_err)
    );
    memory_controller_32 #(.WAIT_STATES(15)) dut_ws15 (
        .clk(clk), .rst(rst), .bus(bus_b),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_en(b_ram_en), .ram_we(b_ram_we),
        .ram_rdata(b_ram_rdata), .io_tx_data(b_tx_data), .io_tx_valid(b_tx_valid),
        .io_tx_ready(1'b1), .bus_error(b_err)
    );
    initial begin
        a_ram_rdata = 32'h0;
        b_ram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (a_ram_en && !a_ram_we) a_ram_rdata <= 32'hC0DE_0000 | 32'(a_ram_addr);
        if (b_ram_en && !b_ram_we) b_ram_rdata <= 32'hC0DE_0000 | 32'(b_ram_addr);
    end

    // Drives one request (caller is just after a rising edge) and records what
    // the bus did until cpu_ready rises. lat = index of the DONE cycle, -1 on timeout.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int tx_low, input logic hold,
                           output int lat, output logic [31:0] rdata, output logic oe,
                           output logic err, output int en_cnt, output int we_cnt,
                           output logic [13:0] en_addr, output int en_first,
                           output int txv_cnt, output logic txd_ok);
        lat = -1; rdata = 'x; oe = 1'bx; err = 1'bx;
        en_cnt = 0; we_cnt = 0; en_addr = '0; en_first = -1; txv_cnt = 0; txd_ok = 1'b1;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int c = 0; c < 100; c++) begin
            if (tx_low >= 0) io_tx_ready = (c > tx_low);
            @(negedge clk);
            if (ram_en) begin
                en_cnt++;
                en_addr = ram_addr;
                if (en_first < 0) en_first = c;
                if (ram_we) we_cnt++;
            end
            if (io_tx_valid) begin
                txv_cnt++;
                if (io_tx_data !== wdata[7:0]) txd_ok = 1'b0;
            end
            if (bus.cpu_ready === 1'b1) begin
                lat = c; rdata = bus.cpu_rdata; oe = bus.cpu_rdata_oe; err = bus_error;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!hold) begin
            bus.cpu_read  = 1'b0;
            bus.cpu_write = 1'b0;
        end
        if (tx_low >= 0) io_tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.cpu_ready); end
        total++; if ({ram_en, ram_we, io_tx_valid, bus.cpu_rdata_oe, bus_error} !== 5'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 00000", {ram_en, ram_we, io_tx_valid, bus.cpu_rdata_oe, bus_error}); end
        total++; if ({bus.cpu_rdata, ram_wdata, ram_addr, io_tx_data} !== 86'h0) begin bad++; $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h tx=%h want 0", bus.cpu_rdata, ram_wdata, ram_addr, io_tx_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ram();
        int lat, en, we, ef, tv; logic [31:0] rd; logic oe, er, tok; logic [13:0] ea;
        run_txn(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 5) begin bad++; $display("FAIL ram_wr_latency: got %0d want 5", lat); end
        total++; if (en !== 1 || we !== 1 || ea !== 14'd4) begin bad++; $display("FAIL ram_wr_pulse: got en=%0d we=%0d addr=%0d want 1 1 4", en, we, ea); end
        total++; if (oe !== 1'b0 || tv !== 0) begin bad++; $display("FAIL ram_wr_oe: got oe=%b txv=%0d want 0 0", oe, tv); end
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 5) begin bad++; $display("FAIL ram_rd_latency: got %0d want 5", lat); end
        total++; if (rd !== 32'h1234_5678 || oe !== 1'b1) begin bad++; $display("FAIL ram_rd_data: got %h oe=%b want 12345678 1", rd, oe); end
        total++; if (en !== 1 || we !== 0 || ea !== 14'd4) begin bad++; $display("FAIL ram_rd_pulse: got en=%0d we=%0d addr=%0d want 1 0 4", en, we, ea); end
        // Top word of RAM
        run_txn(1'b0, 1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 5 || ea !== 14'h3FFF || er !== 1'b0) begin bad++; $display("FAIL ram_top_wr: got lat=%0d addr=%h err=%b want 5 3fff 0", lat, ea, er); end
    endtask

    task automatic test_errors();
        int lat, en, we, ef, tv; logic [31:0] rd; logic oe, er, tok; logic [13:0] ea;
        run_txn(1'b1, 1'b0, 32'h0000_0002, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 1 || rd !== 32'hDEAD_BEEF || er !== 1'b1 || en !== 0) begin bad++; $display("FAIL err_misaligned: got lat=%0d rd=%h err=%b en=%0d want 1 deadbeef 1 0", lat, rd, er, en); end
        run_txn(1'b0, 1'b1, 32'h0002_0000, 32'h5555_AAAA, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 1 || er !== 1'b1 || en !== 0 || tv !== 0 || oe !== 1'b0) begin bad++; $display("FAIL err_wr_range: got lat=%0d err=%b en=%0d txv=%0d oe=%b want 1 1 0 0 0", lat, er, en, tv, oe); end
        run_txn(1'b1, 1'b0, 32'h0001_0000, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 1 || rd !== 32'hDEAD_BEEF || en !== 0) begin bad++; $display("FAIL err_ram_edge: got lat=%0d rd=%h en=%0d want 1 deadbeef 0", lat, rd, en); end
        run_txn(1'b1, 1'b0, MMIO + 32'd4, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 1 || rd !== 32'h3) begin bad++; $display("FAIL status_rd_set: got lat=%0d rd=%h want 1 00000003", lat, rd); end
        run_txn(1'b0, 1'b1, MMIO + 32'd4, 32'hFFFF_FFFF, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 1 || er !== 1'b0) begin bad++; $display("FAIL status_clear: got lat=%0d err=%b want 1 0", lat, er); end
        run_txn(1'b1, 1'b0, MMIO + 32'd4, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL status_rd_clr: got %h want 00000001", rd); end
        run_txn(1'b1, 1'b0, MMIO, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 1 || rd !== 32'h0 || tv !== 0 || er !== 1'b0) begin bad++; $display("FAIL tx_read: got lat=%0d rd=%h txv=%0d err=%b want 1 0 0 0", lat, rd, tv, er); end
    endtask

    task automatic test_tx();
        int lat, en, we, ef, tv; logic [31:0] rd; logic oe, er, tok; logic [13:0] ea;
        run_txn(1'b0, 1'b1, MMIO, 32'h0000_0041, 4, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 6) begin bad++; $display("FAIL tx_stall_latency: got %0d want 6", lat); end
        total++; if (tv !== 5 || tok !== 1'b1 || en !== 0) begin bad++; $display("FAIL tx_stall_valid: got txv=%0d data_ok=%b en=%0d want 5 1 0", tv, tok, en); end
        run_txn(1'b0, 1'b1, MMIO, 32'h0000_0042, 0, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 2 || tv !== 1 || tok !== 1'b1) begin bad++; $display("FAIL tx_ready_high: got lat=%0d txv=%0d data_ok=%b want 2 1 1", lat, tv, tok); end
    endtask

    task automatic test_rd_wr_both();
        int lat, en, we, ef, tv; logic [31:0] rd; logic oe, er, tok; logic [13:0] ea;
        run_txn(1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 1 || rd !== 32'hDEAD_BEEF || er !== 1'b1 || en !== 0) begin bad++; $display("FAIL rw_both: got lat=%0d rd=%h err=%b en=%0d want 1 deadbeef 1 0", lat, rd, er, en); end
        total++; if (mem[2] !== 32'h0) begin bad++; $display("FAIL rw_both_ram: got %h want 0", mem[2]); end
    endtask

    task automatic test_mid_reset();
        int lat, en, we, ef, tv; logic [31:0] rd; logic oe, er, tok; logic [13:0] ea;
        bus.cpu_addr = 32'h0000_0010;
        bus.cpu_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.cpu_ready !== 1'b0 || ram_en !== 1'b0 || bus.cpu_rdata_oe !== 1'b0 || io_tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: got ready=%b en=%b oe=%b txv=%b want 0 0 0 0", bus.cpu_ready, ram_en, bus.cpu_rdata_oe, io_tx_valid); end
        total++; if (bus_error !== 1'b0 || bus.cpu_rdata !== 32'h0 || ram_addr !== 14'h0 || io_tx_data !== 8'h0) begin bad++; $display("FAIL midrst_data: got err=%b rd=%h addr=%h tx=%h want 0 0 0 0", bus_error, bus.cpu_rdata, ram_addr, io_tx_data); end
        bus.cpu_read = 1'b0;
        #1;
        total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle_ready: got %b want 1", bus.cpu_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 5 || rd !== 32'h1234_5678) begin bad++; $display("FAIL midrst_reread: got lat=%0d rd=%h want 5 12345678", lat, rd); end
    endtask

    task automatic test_back_to_back();
        int lat, en, we, ef, tv; logic [31:0] rd; logic oe, er, tok; logic [13:0] ea;
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, -1, 1'b1, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 5 || rd !== 32'h1234_5678 || ef !== 1) begin bad++; $display("FAIL b2b_first: got lat=%0d rd=%h en_cycle=%0d want 5 12345678 1", lat, rd, ef); end
        run_txn(1'b1, 1'b0, 32'h0000_FFFC, 32'h0, -1, 1'b0, lat, rd, oe, er, en, we, ea, ef, tv, tok);
        total++; if (lat !== 5 || rd !== 32'hCAFE_F00D || ef !== 1 || en !== 1) begin bad++; $display("FAIL b2b_second: got lat=%0d rd=%h en_cycle=%0d en=%0d want 5 cafef00d 1 1", lat, rd, ef, en); end
    endtask

    task automatic test_wait_sweep();
        int lat_a = -1, lat_b = -1, en_a = 0;
        logic [31:0] rd_a = '0, rd_b = '0;
        bus_a.cpu_addr = 32'h0000_0020; bus_a.cpu_read = 1'b1;
        bus_b.cpu_addr = 32'h0000_0040; bus_b.cpu_read = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (lat_a < 0 && a_ram_en) en_a++;
            if (lat_a < 0 && bus_a.cpu_ready === 1'b1) begin lat_a = c; rd_a = bus_a.cpu_rdata; end
            if (lat_b < 0 && bus_b.cpu_ready === 1'b1) begin lat_b = c; rd_b = bus_b.cpu_rdata; end
            @(posedge clk); #1;
            if (lat_a >= 0) bus_a.cpu_read = 1'b0;
            if (lat_b >= 0) bus_b.cpu_read = 1'b0;
            if (lat_a >= 0 && lat_b >= 0) break;
        end
        bus_a.cpu_read = 1'b0; bus_b.cpu_read = 1'b0;
        total++; if (lat_a !== 3 || rd_a !== 32'hC0DE_0008 || en_a !== 1) begin bad++; $display("FAIL ws0_read: got lat=%0d rd=%h en=%0d want 3 c0de0008 1", lat_a, rd_a, en_a); end
        total++; if (lat_b !== 18 || rd_b !== 32'hC0DE_0010) begin bad++; $display("FAIL ws15_read: got lat=%0d rd=%h want 18 c0de0010", lat_b, rd_b); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0; bus_a.cpu_read = 1'b0; bus_a.cpu_write = 1'b0;
        bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0; bus_b.cpu_read = 1'b0; bus_b.cpu_write = 1'b0;
        io_tx_ready = 1'b1;
        test_reset();
        test_ram();
        test_errors();
        test_tx();
        test_rd_wr_both();
        test_mid_reset();
        test_back_to_back();
        test_wait_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
